// File: rtl/recip_index_search_pkg.sv
// Shared constants for the reciprocal table and its inverse search.
// The table is strictly decreasing, which the linear scan relies on.
package recip_index_search_pkg;

  localparam int RECIP_DEPTH = 16;
  localparam int IDX_W       = 4;
  localparam int FRAC_W      = 8;
  localparam int DATA_W      = 16;

  localparam logic [FRAC_W-1:0] RECIP [RECIP_DEPTH] = '{
    8'hFF, 8'h80, 8'h55, 8'h40, 8'h33, 8'h2A, 8'h24, 8'h20,
    8'h1C, 8'h19, 8'h17, 8'h15, 8'h13, 8'h12, 8'h11, 8'h10
  };

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  function automatic logic [FRAC_W-1:0] recip_entry(input logic [IDX_W-1:0] idx);
    return RECIP[idx];
  endfunction

endpackage

// File: rtl/recip_index_search_rom.sv
// Combinational lookup of one reciprocal table entry.
module recip_index_search_rom
  import recip_index_search_pkg::*;
(
  input  logic [IDX_W-1:0]  addr,
  output logic [FRAC_W-1:0] data
);

  assign data = recip_entry(addr);

endmodule

// File: rtl/recip_index_search.sv
// Recovers the table index whose reciprocal is nearest to a Q0.8 value
// by scanning the decreasing table one entry per clock.
module recip_index_search
  import recip_index_search_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  index,
  output logic              exact
);

  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    cnt;
  logic [IDX_W-1:0]    cnt_prev;
  logic [FRAC_W-1:0]   v_q;
  logic                sat_q;
  logic                found;
  logic [FRAC_W-1:0]   cur;
  logic [FRAC_W-1:0]   prev;
  logic [FRAC_W-1:0]   d_lo;
  logic [FRAC_W-1:0]   d_hi;
  logic [FRAC_W-1:0]   sel_entry;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_valid;
  logic                sel_exact;

  assign cnt_prev = cnt - 4'd1;

  recip_index_search_rom u_rom_cur (
    .addr (cnt),
    .data (cur)
  );

  recip_index_search_rom u_rom_prev (
    .addr (cnt_prev),
    .data (prev)
  );

  // Next state plus the per-cycle nearest-neighbour decision; the selection
  // is registered first and the DONE pulse follows one cycle later.
  always_comb begin
    state_next = state;
    sel_valid  = 1'b0;
    sel_idx    = cnt;
    sel_entry  = cur;
    d_lo       = '0;
    d_hi       = '0;
    unique case (state)
      IDLE: begin
        if (start) state_next = SCAN;
      end
      SCAN: begin
        if (found) begin
          state_next = DONE;
        end else if (cur <= v_q) begin
          sel_valid = 1'b1;
          if (cnt != '0) begin
            d_lo = v_q - cur;
            d_hi = prev - v_q;
            if (d_lo >= d_hi) begin
              sel_idx   = cnt_prev;
              sel_entry = prev;
            end
          end
        end else if (cnt == IDX_W'(RECIP_DEPTH - 1)) begin
          sel_valid = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    sel_exact = (v_q == sel_entry) && !sat_q;
  end

  // Oversized inputs saturate to the largest reciprocal but can never be exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      v_q   <= '0;
      sat_q <= 1'b0;
      found <= 1'b0;
      index <= '0;
      exact <= 1'b0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (start) begin
            v_q   <= (value[DATA_W-1:FRAC_W] == '0) ? value[FRAC_W-1:0] : 8'hFF;
            sat_q <= |value[DATA_W-1:FRAC_W];
            cnt   <= '0;
            found <= 1'b0;
          end
        end
        SCAN: begin
          if (!found) begin
            if (sel_valid) begin
              index <= sel_idx;
              exact <= sel_exact;
              found <= 1'b1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_recip_index_search.sv
// Scoreboard bench for recip_index_search: stimulus queues expected results,
// a monitor compares them against each done pulse.
module tb_recip_index_search;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] value;
  logic        busy;
  logic        done;
  logic [3:0]  index;
  logic        exact;

  typedef struct {
    logic [3:0] idx;
    logic       ex;
    int         due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [7:0] TBL [16] = '{
    8'd255, 8'd128, 8'd85, 8'd64, 8'd51, 8'd42, 8'd36, 8'd32,
    8'd28,  8'd25,  8'd23, 8'd21, 8'd19, 8'd18, 8'd17, 8'd16
  };

  recip_index_search dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .index (index),
    .exact (exact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Nearest entry by absolute distance, ties to lower index; latency from
  // the first entry not above the value.
  task automatic refModel(input logic [15:0] val, output logic [3:0] idx,
                          output logic ex, output int lat);
    logic [7:0] v;
    int best, bestd, d, k;
    v = (val[15:8] != 0) ? 8'hFF : val[7:0];
    best = 0;
    bestd = 256;
    k = 15;
    for (int n = 0; n < 16; n++) begin
      d = (int'(v) > int'(TBL[n])) ? int'(v) - int'(TBL[n]) : int'(TBL[n]) - int'(v);
      if (d < bestd) begin
        bestd = d;
        best = n;
      end
    end
    for (int n = 15; n >= 0; n--) if (TBL[n] <= v) k = n;
    idx = best[3:0];
    ex = (TBL[best] == v) && (val[15:8] == 0);
    lat = k + 2;
  endtask

  task automatic applyStimulus(input logic [15:0] val, input logic [3:0] eidx,
                               input logic eex, input int elat);
    int t;
    t = 0;
    while ((busy || done) && t < 50) begin
      @(negedge clk);
      t++;
    end
    value = val;
    start = 1'b1;
    q.push_back('{idx: eidx, ex: eex, due: cyc + 1 + elat});
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      checkOutput("timeout_pending", q.size(), 0);
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        checkOutput("spurious_done", int'(done), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        checkOutput("index", int'(index), int'(e.idx));
        checkOutput("exact", int'(exact), int'(e.ex));
        checkOutput("done_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    logic [3:0] ridx;
    logic       rex;
    int         rlat;
    int         t;
    rst = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_index", int'(index), 0);
    checkOutput("reset_exact", int'(exact), 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(16'h0080, 4'd1,  1'b1, 3);
    applyStimulus(16'h00FF, 4'd0,  1'b1, 2);
    applyStimulus(16'h004A, 4'd3,  1'b0, 5);
    applyStimulus(16'h006A, 4'd2,  1'b0, 4);
    applyStimulus(16'h0018, 4'd9,  1'b0, 12);
    applyStimulus(16'h0000, 4'd15, 1'b0, 17);
    applyStimulus(16'h1234, 4'd0,  1'b0, 2);

    // Extra starts during SCAN and in the DONE cycle must be ignored.
    value = 16'h0040;
    start = 1'b1;
    q.push_back('{idx: 4'd3, ex: 1'b1, due: cyc + 1 + 5});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    value = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    checkOutput("handshake_done_seen", int'(done), 1);
    value = 16'h00FF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_cycle_start_busy", int'(busy), 0);
    repeat (4) @(negedge clk);
    checkOutput("hold_index", int'(index), 3);
    checkOutput("hold_exact", int'(exact), 1);
    checkOutput("handshake_queue", q.size(), 0);
    q.delete();

    // Reset mid-scan aborts with no done pulse.
    value = 16'h0005;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_index", int'(index), 0);
    checkOutput("abort_exact", int'(exact), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("abort_idle", int'(busy), 0);

    for (int v = 0; v < 256; v++) begin
      refModel(16'(v), ridx, rex, rlat);
      applyStimulus(16'(v), ridx, rex, rlat);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
